// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: md_op encodings, MIPS funct codes and op-class helpers for the multiply/divide unit.
package mdu_ctrl_pkg;
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  function automatic logic is_div(input logic [3:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
  function automatic logic is_muldiv(input logic [3:0] op);
    return op == MD_MULT || op == MD_MULTU || is_div(op);
  endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply and divide producing the HI/LO result pair.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);
  logic signed [63:0] sprod;
  logic [63:0]        uprod;
  logic [31:0]        dvs, uq, ur;
  logic signed [31:0] sq, sr;
  assign sprod = $signed(rs_val) * $signed(rt_val);
  assign uprod = {32'b0, rs_val} * {32'b0, rt_val};
  // A zero divisor is replaced so the dividers never see it; the result is discarded anyway.
  assign div_zero = is_div(md_op) && rt_val == '0;
  assign dvs = rt_val == '0 ? 32'd1 : rt_val;
  assign sq = $signed(rs_val) / $signed(dvs);
  assign sr = $signed(rs_val) % $signed(dvs);
  assign uq = rs_val / dvs;
  assign ur = rs_val % dvs;
  assign res_hi = md_op == MD_MULT  ? sprod[63:32] :
                  md_op == MD_MULTU ? uprod[63:32] :
                  md_op == MD_DIV   ? sr :
                  md_op == MD_DIVU  ? ur : '0;
  assign res_lo = md_op == MD_MULT  ? sprod[31:0] :
                  md_op == MD_MULTU ? uprod[31:0] :
                  md_op == MD_DIV   ? sq :
                  md_op == MD_DIVU  ? uq : '0;
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer holding HI/LO with busy counter and stall request.
// Defining MDU_CANCEL_EN adds the cancel input that flushes the E-stage operation.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
`ifdef MDU_CANCEL_EN
  ,input  logic        cancel
`endif
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [31:0]        hi_nx, lo_nx, pend_hi, pend_lo, pend_hi_nx, pend_lo_nx, res_hi, res_lo;
  logic               pend_zero, pend_zero_nx, div_zero, kill;
`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif
  mdu_arith u_arith (
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );
  assign busy     = state == RUN;
  assign md_stall = busy | (start & is_muldiv(md_op));
  assign md_rdata = md_op == MD_MFHI ? hi : md_op == MD_MFLO ? lo : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_zero <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      hi        <= hi_nx;
      lo        <= lo_nx;
      pend_hi   <= pend_hi_nx;
      pend_lo   <= pend_lo_nx;
      pend_zero <= pend_zero_nx;
    end
  end
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    hi_nx        = hi;
    lo_nx        = lo;
    pend_hi_nx   = pend_hi;
    pend_lo_nx   = pend_lo;
    pend_zero_nx = pend_zero;
    if (kill) begin
      state_nx     = IDLE;
      cnt_nx       = '0;
      pend_hi_nx   = '0;
      pend_lo_nx   = '0;
      pend_zero_nx = 1'b0;
    end else if (state == RUN) begin
      cnt_nx = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        state_nx = IDLE;
        hi_nx    = pend_zero ? hi : pend_hi;
        lo_nx    = pend_zero ? lo : pend_lo;
      end
    end else if (start && is_muldiv(md_op)) begin
      state_nx     = RUN;
      cnt_nx       = is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      pend_hi_nx   = res_hi;
      pend_lo_nx   = res_lo;
      pend_zero_nx = div_zero;
    end else if (start) begin
      hi_nx = md_op == MD_MTHI ? rs_val : hi;
      lo_nx = md_op == MD_MTLO ? rs_val : lo;
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed-vector bench for mdu_ctrl with hand-computed HI/LO results and busy lengths.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;
  logic        clk = 0, reset = 1, start = 0;
  logic [3:0]  md_op = MD_NONE;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        busy, md_stall;
  logic [31:0] hi, lo, md_rdata;
  int          vecs = 0, errs = 0;
`ifdef MDU_CANCEL_EN
  logic        cancel = 0;
`endif
  mdu_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo),
    .md_rdata (md_rdata)
`ifdef MDU_CANCEL_EN
    ,.cancel  (cancel)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Issue a mult/div at a negedge, then count busy cycles (bounded) checking the stall each cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
    int k = 0;
    start = 1; md_op = op; rs_val = a; rt_val = b;
    #1 chk({tag, " stall_start"}, 32'(md_stall), 32'd1);
    @(negedge clk);
    start = 0; md_op = MD_NONE;
    while (busy && k < 40) begin
      chk({tag, " stall_busy"}, 32'(md_stall), 32'd1);
      k++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 32'(k), 32'(n));
  endtask
  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    start = 1; md_op = op; rs_val = v;
    @(negedge clk);
    start = 0; md_op = MD_NONE;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst stall", 32'(md_stall), 32'd0);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5);
    chk("mult hi", hi, 32'hFFFFFFFF);
    chk("mult lo", lo, 32'hFFFFFFFA);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 10);
    chk("divu hi", hi, 32'd2);
    chk("divu lo", lo, 32'd14);
    run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10);
    chk("div hi", hi, 32'hFFFFFFFF);
    chk("div lo", lo, 32'hFFFFFFFD);
    start = 1; md_op = MD_MTHI; rs_val = 32'h1234;
    #1 chk("mthi stall", 32'(md_stall), 32'd0);
    @(negedge clk);
    mt(MD_MTLO, 32'h5678);
    chk("mt busy", 32'(busy), 32'd0);
    chk("mthi hi", hi, 32'h1234);
    chk("mtlo lo", lo, 32'h5678);
    run_op("div0", MD_DIV, 32'd55, 32'd0, 10);
    chk("div0 hi", hi, 32'h1234);
    chk("div0 lo", lo, 32'h5678);
    md_op = MD_MFHI; #1 chk("mfhi rdata", md_rdata, 32'h1234);
    md_op = MD_MFLO; #1 chk("mflo rdata", md_rdata, 32'h5678);
    md_op = MD_MULT; #1 chk("other rdata", md_rdata, 32'h0);
    start = 1; md_op = 4'hF; rs_val = 32'hDEAD; rt_val = 32'd1;
    #1 chk("unk stall", 32'(md_stall), 32'd0);
    @(negedge clk);
    start = 0; md_op = MD_NONE;
    chk("unk busy", 32'(busy), 32'd0);
    chk("unk hi", hi, 32'h1234);
    chk("unk lo", lo, 32'h5678);
    start = 1; md_op = MD_MULTU; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    start = 0; md_op = MD_NONE;
    @(negedge clk);
    chk("sb busy2", 32'(busy), 32'd1);
    mt(MD_MTLO, 32'hAAAA);
    chk("sb lo_held", lo, 32'h5678);
    repeat (5) @(negedge clk);
    chk("sb busy_end", 32'(busy), 32'd0);
    chk("sb hi", hi, 32'h0);
    chk("sb lo", lo, 32'd6);
    start = 1; md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 0; md_op = MD_NONE;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid hi", hi, 32'h0);
    chk("rstmid lo", lo, 32'h0);
    run_op("mult45", MD_MULT, 32'd4, 32'd5, 5);
    chk("mult45 hi", hi, 32'h0);
    chk("mult45 lo", lo, 32'd20);
`ifdef MDU_CANCEL_EN
    mt(MD_MTHI, 32'h1);
    mt(MD_MTLO, 32'h2);
    start = 1; md_op = MD_MULT; rs_val = 32'd4; rt_val = 32'd5;
    @(negedge clk);
    start = 0; md_op = MD_NONE;
    @(negedge clk);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    chk("cancel busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("cancel hi", hi, 32'h1);
    chk("cancel lo", lo, 32'h2);
    cancel = 1;
    mt(MD_MTHI, 32'h99);
    cancel = 0;
    chk("cancel mthi", hi, 32'h1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
